// File: rtl/cop0_pkg.sv
// Shared CP0 definitions: register indices, Status/Cause field positions,
// exception codes, sequencer states and the priority-slot to ExcCode table.
package cop0_pkg;

    // CP0 register indices
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    // Status field positions
    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_UM    = 4;
    localparam int ST_IM_LO = 8;

    // Cause field positions
    localparam int CA_EXC_LO = 2;
    localparam int CA_IP_LO  = 8;

    localparam logic [31:0] KERNEL_VEC_DEFAULT = 32'h8000_0180;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12,
        EXC_TR   = 5'd13
    } exc_code_t;

    typedef enum logic {
        S_IDLE,
        S_REDIRECT
    } seq_state_t;

    // Request slot (0 = highest priority) to architectural ExcCode.
    function automatic exc_code_t exc_code_of(input logic [3:0] slot);
        case (slot)
            4'd0:    return EXC_ADEL;
            4'd1:    return EXC_ADES;
            4'd2:    return EXC_SYS;
            4'd3:    return EXC_RI;
            4'd4:    return EXC_OV;
            default: return EXC_TR;
        endcase
    endfunction

endpackage

// File: rtl/cop0_exc_unit_if.sv
// CP0 register access bus (mtc0 write port plus combinational read port).
interface cop0_exc_unit_if;
    logic        mtc0_en;
    logic [4:0]  rreg;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output mtc0_en, rreg, wreg, wdata, input rdata);
    modport slave  (input mtc0_en, rreg, wreg, wdata, output rdata);
endinterface

// File: rtl/cop0_prio_enc.sv
// Lowest-index-first priority encoder with a valid flag.
module cop0_prio_enc #(
    parameter int  WIDTH = 6,
    localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic [IW-1:0]    idx,
    output logic             valid
);

    // Scan from the top down so the lowest set bit is the last one to win.
    // NOTE: every output gets a default first, so no latch is inferred.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cop0_exc_unit.sv
// CP0 register file with exception-entry / ERET sequencer.
// Optional timer (Count/Compare, IP7 override) enabled by `define COP0_TIMER_EN.
module cop0_exc_unit
    import cop0_pkg::*;
#(
    parameter int          NUM_EXC    = 6,
    parameter int          NUM_HW_INT = 6,
    parameter logic [31:0] KERNEL_VEC = KERNEL_VEC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    cop0_exc_unit_if.slave        bus,
    input  logic [NUM_EXC-1:0]    exc_req,
    input  logic                  exc_is_addr,
    input  logic [31:0]           epc_in,
    input  logic [31:0]           badvaddr_in,
    input  logic [NUM_HW_INT-1:0] hw_int,
    input  logic                  eret,
    output logic                  flush,
    output logic [31:0]           redirect_pc,
    output logic                  user_mode,
    output logic                  exc_level,
    output logic [31:0]           epc_out,
    output logic                  int_pending
);

    localparam int IW = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1;

    seq_state_t  state_q, state_next;
    logic        take_exc, take_eret;
    logic [IW-1:0] prio_idx;
    logic        exc_valid;

    logic        ie_q, exl_q, um_q;
    logic [7:0]  im_q;
    exc_code_t   exc_code_q;
    logic [1:0]  ip_sw_q;
    logic [5:0]  ip_hw_q;
    logic        ip7;
    logic [7:0]  ip;
    logic [31:0] epc_q, badvaddr_q;
    logic [31:0] status_word, cause_word;

    logic wr_status, wr_cause, wr_epc, wr_badvaddr;

    assign wr_status   = bus.mtc0_en && (bus.wreg == REG_STATUS);
    assign wr_cause    = bus.mtc0_en && (bus.wreg == REG_CAUSE);
    assign wr_epc      = bus.mtc0_en && (bus.wreg == REG_EPC);
    assign wr_badvaddr = bus.mtc0_en && (bus.wreg == REG_BADVADDR);

    cop0_prio_enc #(.WIDTH(NUM_EXC)) u_prio (
        .req   (exc_req),
        .idx   (prio_idx),
        .valid (exc_valid)
    );

`ifdef COP0_TIMER_EN
    logic [31:0] count_q, compare_q;
    logic        timer_flag_q;
    logic        wr_count, wr_compare;

    assign wr_count   = bus.mtc0_en && (bus.wreg == REG_COUNT);
    assign wr_compare = bus.mtc0_en && (bus.wreg == REG_COMPARE);

    // Free-running counter with a sticky match flag cleared by a Compare write.
    // NOTE: non-blocking assignments make every register sample pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q      <= '0;
            compare_q    <= '0;
            timer_flag_q <= 1'b0;
        end else begin
            count_q <= wr_count ? bus.wdata : count_q + 32'd1;
            if (wr_compare) compare_q <= bus.wdata;
            if (wr_compare)                  timer_flag_q <= 1'b0;
            else if (count_q == compare_q)   timer_flag_q <= 1'b1;
        end
    end

    assign ip7 = timer_flag_q;
`else
    assign ip7 = ip_hw_q[5];
`endif

    assign ip          = {ip7, ip_hw_q[4:0], ip_sw_q};
    assign int_pending = ie_q && !exl_q && |(ip & im_q);
    assign user_mode   = um_q;
    assign exc_level   = exl_q;
    assign epc_out     = epc_q;
    assign flush       = (state_q == S_REDIRECT);

    // Sequencer decision: exceptions/interrupts only when EXL=0, ERET only when EXL=1.
    always_comb begin
        state_next = state_q;
        take_exc   = 1'b0;
        take_eret  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!exl_q && (exc_valid || int_pending)) begin
                    take_exc   = 1'b1;
                    state_next = S_REDIRECT;
                end else if (eret && exl_q) begin
                    take_eret  = 1'b1;
                    state_next = S_REDIRECT;
                end
            end
            S_REDIRECT: state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // State register and registered redirect target.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            redirect_pc <= '0;
        end else begin
            state_q <= state_next;
            if (take_exc)       redirect_pc <= KERNEL_VEC;
            else if (take_eret) redirect_pc <= epc_q;
        end
    end

    // Status: sequencer updates take precedence over an mtc0 in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ie_q  <= 1'b0;
            exl_q <= 1'b0;
            um_q  <= 1'b0;
            im_q  <= '0;
        end else if (take_exc) begin
            exl_q <= 1'b1;
            um_q  <= 1'b0;
        end else if (take_eret) begin
            exl_q <= 1'b0;
            um_q  <= 1'b1;
        end else if (wr_status) begin
            ie_q  <= bus.wdata[ST_IE];
            exl_q <= bus.wdata[ST_EXL];
            um_q  <= bus.wdata[ST_UM];
            im_q  <= bus.wdata[ST_IM_LO +: 8];
        end
    end

    // Cause: hardware IP sampled every cycle; only IP[1:0] is software-writable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_code_q <= EXC_INT;
            ip_sw_q    <= '0;
            ip_hw_q    <= '0;
        end else begin
            ip_hw_q <= 6'(hw_int);
            if (take_exc)
                exc_code_q <= exc_valid ? exc_code_of(4'(prio_idx)) : EXC_INT;
            else if (wr_cause)
                ip_sw_q <= bus.wdata[CA_IP_LO +: 2];
        end
    end

    // EPC / BadVAddr capture on entry, otherwise mtc0-writable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            if (take_exc)    epc_q <= epc_in;
            else if (wr_epc) epc_q <= bus.wdata;
            if (take_exc && exc_is_addr) badvaddr_q <= badvaddr_in;
            else if (wr_badvaddr)        badvaddr_q <= bus.wdata;
        end
    end

    // Architectural views of Status/Cause and the combinational read port.
    always_comb begin
        status_word                  = '0;
        status_word[ST_IE]           = ie_q;
        status_word[ST_EXL]          = exl_q;
        status_word[ST_UM]           = um_q;
        status_word[ST_IM_LO +: 8]   = im_q;
        cause_word                   = '0;
        cause_word[CA_EXC_LO +: 5]   = exc_code_q;
        cause_word[CA_IP_LO +: 8]    = ip;
        case (bus.rreg)
            REG_BADVADDR: bus.rdata = badvaddr_q;
            REG_STATUS:   bus.rdata = status_word;
            REG_CAUSE:    bus.rdata = cause_word;
            REG_EPC:      bus.rdata = epc_q;
`ifdef COP0_TIMER_EN
            REG_COUNT:    bus.rdata = count_q;
            REG_COMPARE:  bus.rdata = compare_q;
`endif
            default:      bus.rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cop0_exc_unit.sv
// Self-checking bench for cop0_exc_unit: behavioural model + per-cycle compare,
// directed literal checks, then randomized traffic.
module tb_cop0_exc_unit;

    localparam logic [31:0] KVEC = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  exc_req;
    logic        exc_is_addr;
    logic [31:0] epc_in, badvaddr_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic        flush, user_mode, exc_level, int_pending;
    logic [31:0] redirect_pc, epc_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    cop0_exc_unit_if bus ();

    cop0_exc_unit #(.NUM_EXC(6), .NUM_HW_INT(6), .KERNEL_VEC(KVEC)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .exc_req     (exc_req),
        .exc_is_addr (exc_is_addr),
        .epc_in      (epc_in),
        .badvaddr_in (badvaddr_in),
        .hw_int      (hw_int),
        .eret        (eret),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .user_mode   (user_mode),
        .exc_level   (exc_level),
        .epc_out     (epc_out),
        .int_pending (int_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_ie, m_exl, m_um, m_flush, m_tflag;
    logic [7:0]  m_im;
    logic [4:0]  m_code;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_iphw;
    logic [31:0] m_epc, m_bad, m_target, m_count, m_compare;

    function automatic logic [4:0] exp_code(input logic [5:0] req);
        int tab[6] = '{4, 5, 8, 10, 12, 13};
        for (int i = 0; i < 6; i++)
            if (req[i]) return 5'(tab[i]);
        return 5'd0;
    endfunction

    function automatic logic [7:0] m_ip();
`ifdef COP0_TIMER_EN
        return {m_tflag, m_iphw[4:0], m_ipsw};
`else
        return {m_iphw[5], m_iphw[4:0], m_ipsw};
`endif
    endfunction

    function automatic bit m_pend();
        return m_ie && !m_exl && (|(m_ip() & m_im));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        case (idx)
            5'd8:  return m_bad;
            5'd12: return {16'h0, m_im, 3'b0, m_um, 2'b0, m_exl, m_ie};
            5'd13: return {16'h0, m_ip(), 1'b0, m_code, 2'b0};
            5'd14: return m_epc;
`ifdef COP0_TIMER_EN
            5'd9:  return m_count;
            5'd11: return m_compare;
`endif
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            {m_ie, m_exl, m_um, m_flush, m_tflag} = '0;
            m_im = '0; m_code = '0; m_ipsw = '0; m_iphw = '0;
            m_epc = '0; m_bad = '0; m_target = '0; m_count = '0; m_compare = '0;
        end else begin
            bit exc_ev, eret_ev, wr;
            logic [31:0] old_epc, wd;
            logic [4:0] w;
            wr = bus.mtc0_en; w = bus.wreg; wd = bus.wdata;
            old_epc = m_epc;
            exc_ev  = !m_flush && !m_exl && ((|exc_req) || m_pend());
            eret_ev = !m_flush && !exc_ev && eret && m_exl;
            if (exc_ev) begin
                m_code = exp_code(exc_req);
                m_epc  = epc_in;
                if (exc_is_addr) m_bad = badvaddr_in;
                m_exl = 1'b1; m_um = 1'b0;
            end else if (eret_ev) begin
                m_exl = 1'b0; m_um = 1'b1;
            end
            if (wr) begin
                case (w)
                    5'd8:  if (!(exc_ev && exc_is_addr)) m_bad = wd;
                    5'd12: if (!exc_ev && !eret_ev) begin
                               m_ie = wd[0]; m_exl = wd[1]; m_um = wd[4]; m_im = wd[15:8];
                           end
                    5'd13: if (!exc_ev) m_ipsw = wd[9:8];
                    5'd14: if (!exc_ev) m_epc = wd;
                    default: ;
                endcase
            end
            m_iphw = hw_int;
            if (wr && w == 5'd11) m_tflag = 1'b0;
            else if (m_count == m_compare) m_tflag = 1'b1;
            m_count = (wr && w == 5'd9) ? wd : m_count + 32'd1;
            if (wr && w == 5'd11) m_compare = wd;
            m_flush = exc_ev || eret_ev;
            if (exc_ev)       m_target = KVEC;
            else if (eret_ev) m_target = old_epc;
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && reset) begin
            check("flush",       {31'b0, flush},       {31'b0, m_flush});
            check("user_mode",   {31'b0, user_mode},   {31'b0, m_um});
            check("exc_level",   {31'b0, exc_level},   {31'b0, m_exl});
            check("int_pending", {31'b0, int_pending}, {31'b0, m_pend()});
            check("epc_out",     epc_out,              m_epc);
            check("rdata",       bus.rdata,            m_read(bus.rreg));
            if (m_flush) check("redirect_pc", redirect_pc, m_target);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
        bus.mtc0_en = 1'b1; bus.wreg = r; bus.wdata = d;
        tick();
        bus.mtc0_en = 1'b0;
    endtask

    task automatic read_reg(input logic [4:0] r, output logic [31:0] d);
        bus.rreg = r;
        #1;
        d = bus.rdata;
    endtask

    initial begin
        logic [31:0] d;
        reset = 1'b0; exc_req = '0; exc_is_addr = 1'b0; epc_in = '0; badvaddr_in = '0;
        hw_int = '0; eret = 1'b0;
        bus.mtc0_en = 1'b0; bus.rreg = '0; bus.wreg = '0; bus.wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check("rst_flush", {31'b0, flush}, 32'd0);
        check("rst_redirect", redirect_pc, 32'h0);
        check("rst_um", {31'b0, user_mode}, 32'd0);
        check("rst_exl", {31'b0, exc_level}, 32'd0);
        check("rst_int", {31'b0, int_pending}, 32'd0);
        check("rst_epc", epc_out, 32'h0);
        read_reg(5'd8,  d); check("rst_badvaddr", d, 32'h0);
        read_reg(5'd12, d); check("rst_status", d, 32'h0);
        read_reg(5'd13, d); check("rst_cause", d, 32'h0);
        read_reg(5'd14, d); check("rst_epc_reg", d, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        chk_en = 1'b1;
        tick();

        // SYS exception from user mode
        mtc0(5'd12, 32'h0000_0010);
        check("um_set", {31'b0, user_mode}, 32'd1);
        exc_req = 6'b000100; epc_in = 32'h0040_0020;
        tick();
        exc_req = '0;
        check("sys_epc", epc_out, 32'h0040_0020);
        check("sys_exl", {31'b0, exc_level}, 32'd1);
        check("sys_um", {31'b0, user_mode}, 32'd0);
        check("sys_flush", {31'b0, flush}, 32'd1);
        check("sys_redirect", redirect_pc, 32'h8000_0180);
        read_reg(5'd13, d); check("sys_code", {27'b0, d[6:2]}, 32'd8);
        tick();
        check("sys_flush_1cyc", {31'b0, flush}, 32'd0);
        eret = 1'b1; tick(); eret = 1'b0;
        check("eret1_redirect", redirect_pc, 32'h0040_0020);
        tick();

        // Multi-hot address exception, then an ignored second request
        exc_req = 6'b000011; exc_is_addr = 1'b1; badvaddr_in = 32'h0000_0003; epc_in = 32'h0040_0100;
        tick();
        exc_req = '0; exc_is_addr = 1'b0;
        read_reg(5'd13, d); check("adel_code", {27'b0, d[6:2]}, 32'd4);
        read_reg(5'd8,  d); check("adel_badvaddr", d, 32'h0000_0003);
        tick();
        exc_req = 6'b010000; epc_in = 32'h1234_5678;
        tick();
        exc_req = '0;
        check("nest_flush", {31'b0, flush}, 32'd0);
        check("nest_epc", epc_out, 32'h0040_0100);
        check("nest_exl", {31'b0, exc_level}, 32'd1);

        // ERET back to EPC
        eret = 1'b1; tick(); eret = 1'b0;
        check("eret_flush", {31'b0, flush}, 32'd1);
        check("eret_redirect", redirect_pc, 32'h0040_0100);
        check("eret_exl", {31'b0, exc_level}, 32'd0);
        check("eret_um", {31'b0, user_mode}, 32'd1);
        tick();

        // ERET together with exception: exception wins
        eret = 1'b1; exc_req = 6'b001000; epc_in = 32'h0040_0200;
        tick();
        eret = 1'b0; exc_req = '0;
        check("both_redirect", redirect_pc, 32'h8000_0180);
        check("both_exl", {31'b0, exc_level}, 32'd1);
        read_reg(5'd13, d); check("both_code", {27'b0, d[6:2]}, 32'd10);
        tick();
        eret = 1'b1; tick(); eret = 1'b0; tick();

        // Interrupt: IE=1, IM=0x04, hw_int[0]
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001;
        tick();
        check("int_pend", {31'b0, int_pending}, 32'd1);
        tick();
        check("int_exl", {31'b0, exc_level}, 32'd1);
        check("int_flush", {31'b0, flush}, 32'd1);
        read_reg(5'd13, d); check("int_code", {27'b0, d[6:2]}, 32'd0);
        hw_int = '0;
        eret = 1'b1; tick(); eret = 1'b0; tick();
        mtc0(5'd12, 32'h0000_0001);
        hw_int = 6'b000001;
        repeat (3) tick();
        check("masked_pend", {31'b0, int_pending}, 32'd0);
        check("masked_exl", {31'b0, exc_level}, 32'd0);
        hw_int = '0;
        tick();

`ifdef COP0_TIMER_EN
        begin
            bit seen = 1'b0;
            mtc0(5'd11, 32'd10);
            read_reg(5'd13, d); check("tmr_clear", {31'b0, d[15]}, 32'd0);
            mtc0(5'd9, 32'd0);
            for (int i = 0; i < 40 && !seen; i++) begin
                read_reg(5'd13, d);
                if (d[15]) seen = 1'b1;
                else tick();
            end
            check("tmr_seen", {31'b0, seen}, 32'd1);
            read_reg(5'd9, d); check("tmr_count_at_flag", d, 32'd11);
            mtc0(5'd11, 32'd10);
            read_reg(5'd13, d); check("tmr_cleared", {31'b0, d[15]}, 32'd0);
            mtc0(5'd9, 32'hFFFF_FFFF);
            read_reg(5'd9, d); check("tmr_load", d, 32'hFFFF_FFFF);
            tick();
            read_reg(5'd9, d); check("tmr_wrap", d, 32'h0);
        end
`endif

        // Reset asserted mid-REDIRECT
        exc_req = 6'b100000;
        tick();
        exc_req = '0;
        check("mid_flush_on", {31'b0, flush}, 32'd1);
        reset = 1'b0;
        #1;
        check("mid_flush_off", {31'b0, flush}, 32'd0);
        check("mid_exl", {31'b0, exc_level}, 32'd0);
        check("mid_redirect", redirect_pc, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            logic [4:0] regs[7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
            exc_req     = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'b0;
            exc_is_addr = 1'($urandom);
            epc_in      = $urandom;
            badvaddr_in = $urandom;
            if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom);
            eret        = ($urandom_range(0, 3) == 0);
            bus.mtc0_en = ($urandom_range(0, 3) == 0);
            bus.wreg    = regs[$urandom_range(0, 6)];
            bus.wdata   = $urandom;
            bus.rreg    = regs[$urandom_range(0, 6)];
            tick();
        end
        exc_req = '0; eret = 1'b0; bus.mtc0_en = 1'b0; hw_int = '0;
        tick();
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cop0_exc_unit.md
Name: cop0_exc_unit

Overview:
Parametrised successor of the single-channel CP0 block: architectural CP0 register file plus a clocked exception-entry/return sequencer.
- Accepts a vector of prioritised synchronous exception requests and N level-sensitive hardware interrupt lines, masked per Status.IM/IE.
- Captures EPC/BadVAddr/Cause, then issues a registered flush + PC redirect to the pipeline front end.
- Handles ERET.
- Sits beside the decode/execute stages; the fetch stage consumes redirect_pc.

Parameters:
NUM_EXC, 6, number of synchronous exception request lines; bit 0 is highest priority.
NUM_HW_INT, 6, hardware interrupt lines, mapped to Cause.IP[NUM_HW_INT+1:2]; max 6.
KERNEL_VEC, 32'h8000_0180, exception handler entry address.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
mtc0_en  in  1  write wdata to CP0 register wreg
rreg  in  5  read register index
wreg  in  5  write register index
wdata  in  32  write data
rdata  out  32  combinational read of rreg; unimplemented registers read 0
exc_req  in  NUM_EXC  synchronous exception requests, one-hot or multi-hot
exc_is_addr  in  1  the current request carries a faulting address
epc_in  in  32  PC of the faulting instruction
badvaddr_in  in  32  faulting address
hw_int  in  NUM_HW_INT  level interrupt lines
eret  in  1  ERET executed
flush  out  1  one-cycle pipeline flush
redirect_pc  out  32  target PC, valid while flush=1
user_mode  out  1  Status.UM
exc_level  out  1  Status.EXL
epc_out  out  32  EPC register
int_pending  out  1  unmasked, enabled interrupt pending

Behaviour:
- Implemented registers:
  - BadVAddr (8)
  - Status (12): IE bit0, EXL bit1, UM bit4, IM[15:8]
  - Cause (13): ExcCode[6:2], IP[15:8]
  - EPC (14)
- Reset (reset=0, async): all registers 0, state IDLE, flush=0, redirect_pc=0. Outputs follow: user_mode=0, exc_level=0, epc_out=0, int_pending=0.
- Cause.IP[7:2] is sampled from hw_int every cycle (registered, 1-cycle latency); IP[1:0] is software-writable.
- int_pending = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).
- FSM has two states, IDLE and REDIRECT.
- In IDLE, when EXL=0 and (|exc_req or int_pending), on the clock edge:
  - ExcCode: lowest-index set exc_req bit, mapped through the package code table. Synchronous exceptions beat interrupts; an interrupt yields code 0.
  - EPC <= epc_in.
  - BadVAddr <= badvaddr_in only if exc_is_addr.
  - EXL <= 1, UM <= 0.
  - Go to REDIRECT.
- In REDIRECT: flush=1, redirect_pc=KERNEL_VEC for exactly one cycle, then IDLE. Exception-entry latency is therefore request cycle +1.
- ERET in IDLE with EXL=1: EXL <= 0, UM restored to 1, go to REDIRECT with redirect_pc=EPC.
- ERET with EXL=0 is ignored.
- While EXL=1, exc_req and interrupts are ignored (no nesting, no register update).
- All inputs are ignored during REDIRECT except mtc0_en.
- Simultaneous events:
  - exception beats eret (eret dropped);
  - exception-entry updates beat an mtc0 to the same register in the same cycle;
  - an mtc0 to other registers still takes effect.
- Writes to read-only fields are dropped: Cause.IP[7:2], and Cause.ExcCode via mtc0.
- Reset asserted mid-REDIRECT: flush drops immediately (async), state returns to IDLE.

Optional Feature:
COP0_TIMER_EN
- Defined: adds Count (9) and Compare (11).
  - Count increments every cycle and wraps at 2^32.
  - Count==Compare sets a sticky timer flag mirrored in Cause.IP7, overriding hw_int[5].
  - An mtc0 to Compare clears the flag; an mtc0 to Count loads Count.
- Undefined: registers 9 and 11 read 0, IP7 tracks hw_int[5], and there is no counter logic.

Decomposition:
- Shared package cop0_pkg:
  - CP0 register indices
  - Status/Cause bit positions
  - ExcCode constants (INT=0, ADEL=4, ADES=5, SYS=8, RI=10, OV=12, TR=13)
  - priority-to-ExcCode function
  - KERNEL_VEC default
- One natural sub-module: cop0_prio_enc (parametrised lowest-index-first priority encoder with valid flag).

Test Plan:
- reset=0 then release; read regs 8/12/13/14 -> all 0, flush=0, user_mode=0.
- Status=0x0000_0010 via mtc0; exc_req=6'b000100 (SYS slot), epc_in=0x0040_0020 -> next edge EPC=0x0040_0020, ExcCode=8, EXL=1, UM=0; following cycle flush=1, redirect_pc=0x8000_0180 for one cycle.
- exc_req=6'b000011 with exc_is_addr=1, badvaddr_in=0x0000_0003 -> ExcCode from bit 0 (ADEL=4), BadVAddr=0x0000_0003; a second request while EXL=1 -> no state change, no flush.
- Status.IE=1, IM=0x04, hw_int[0]=1 -> int_pending=1 two cycles later, ExcCode=0; with IM=0x00 -> no entry.
- EXL=1, EPC=0x0040_0100, eret=1 -> EXL=0, UM=1, flush=1 with redirect_pc=0x0040_0100; eret together with exc_req -> exception taken, eret dropped.
- With COP0_TIMER_EN: Compare=10, Count=0 -> IP7 set at Count=10; mtc0 Compare clears it; Count=0xFFFF_FFFF wraps to 0.
